// File: rtl/uart_frame_parser_pkg.sv
// Shared types and defaults for the UART command-frame parser and its helpers.
package uart_frame_parser_pkg;

    localparam logic [7:0]  DEF_SOF         = 8'hA5;
    localparam int unsigned DEF_MAX_LEN     = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 34720;
    localparam int unsigned TMO_CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } parser_state_e;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] len;
    } frame_hdr_t;

    // Running frame checksum: plain XOR, no carry.
    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_parser_byte_timeout.sv
// Loadable saturating cycle counter; flags when the count sits at the limit while running.
module uart_frame_parser_byte_timeout
    import uart_frame_parser_pkg::*;
#(
    parameter int unsigned CNT_W = TMO_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expire_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority over load; counting stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A clear or load in the same cycle masks expiry.
    assign expire_c = en_i && !clr_i && !load_i && (count_q == limit_i);

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles [SOF][CMD][LEN][payload][CHK] frames from the UART byte stream and holds them for the consumer.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter logic [7:0]  SOF         = DEF_SOF,
    parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [7:0]                 RxData,
    input  logic                       RxDone,
    input  logic                       FrameAck,
    input  logic [$clog2(MAX_LEN)-1:0] RdAddr,
    output logic [7:0]                 RdData,
    output logic                       FrameValid,
    output logic [7:0]                 Cmd,
    output logic [7:0]                 Len,
    output logic                       ErrChk,
    output logic                       ErrLen,
    output logic                       ErrTimeout,
    output logic                       Overrun,
    output logic                       Busy
);

    localparam int unsigned ADDR_W = $clog2(MAX_LEN);
    localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);

    parser_state_e    state_q, state_d;
    frame_hdr_t       hdr_q, hdr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic             err_chk_q, err_chk_d;
    logic             err_len_q, err_len_d;
    logic             err_to_q, err_to_d;
    logic             overrun_q, overrun_d;
    logic             frame_valid_q;
    logic             busy_q;
    logic             pay_we_c;
    logic             tmo_run_c;
    logic             tmo_expire_c;
    logic [7:0]       pay_q [MAX_LEN];

    // Inter-byte watchdog is only armed between SOF and CHK.
    assign tmo_run_c = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

    uart_frame_parser_byte_timeout #(
        .CNT_W (TMO_CNT_W)
    ) u_byte_timeout (
        .clk_i      (Clk),
        .reset_i    (Reset),
        .en_i       (tmo_run_c),
        .clr_i      (RxDone || !tmo_run_c),
        .load_i     (1'b0),
        .load_val_i ('0),
        .limit_i    (TMO_CNT_W'(TIMEOUT_CYC - 1)),
        .expire_c   (tmo_expire_c)
    );

    // Next-state and datapath updates for the frame parser.
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        pay_we_c  = 1'b0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        overrun_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (RxDone && (RxData == SOF)) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (RxDone) begin
                    hdr_d.cmd = RxData;
                    chk_d     = RxData;
                    state_d   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (RxDone) begin
                    hdr_d.len = RxData;
                    chk_d     = chk_step(chk_q, RxData);
                    idx_d     = '0;
                    if (RxData > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = ST_HUNT;
                    end else if (RxData == 8'h00) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (RxDone) begin
                    pay_we_c = 1'b1;
                    chk_d    = chk_step(chk_q, RxData);
                    idx_d    = idx_q + IDX_W'(1);
                    if ((8'(idx_q) + 8'd1) == hdr_q.len) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (RxDone) begin
                    if (RxData == chk_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_HOLD: begin
                // Bytes arriving while a frame is held are dropped, even alongside the ack.
                if (RxDone) begin
                    overrun_d = 1'b1;
                end
                if (FrameAck) begin
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Expiry never coincides with RxDone, so it cannot override a byte.
        if (tmo_expire_c) begin
            state_d  = ST_HUNT;
            err_to_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_HUNT;
            hdr_q         <= '0;
            idx_q         <= '0;
            chk_q         <= '0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_to_q      <= 1'b0;
            overrun_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            err_chk_q     <= err_chk_d;
            err_len_q     <= err_len_d;
            err_to_q      <= err_to_d;
            overrun_q     <= overrun_d;
            frame_valid_q <= (state_d == ST_HOLD);
            busy_q        <= (state_d != ST_HUNT);
        end
    end

    // Payload storage keeps its contents across reset.
    always_ff @(posedge Clk) begin
        if (pay_we_c) begin
            pay_q[idx_q[ADDR_W-1:0]] <= RxData;
        end
    end

    assign RdData     = (32'(RdAddr) < MAX_LEN) ? pay_q[RdAddr] : 8'h00;
    assign FrameValid = frame_valid_q;
    assign Cmd        = hdr_q.cmd;
    assign Len        = hdr_q.len;
    assign ErrChk     = err_chk_q;
    assign ErrLen     = err_len_q;
    assign ErrTimeout = err_to_q;
    assign Overrun    = overrun_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a queue-based frame model checked every cycle.
module tb_uart_frame_parser;

    localparam int unsigned MAX_LEN     = 16;
    localparam int unsigned TIMEOUT_CYC = 34720;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameAck;
    logic [3:0] RdAddr;
    logic [7:0] RdData;
    logic       FrameValid;
    logic [7:0] Cmd;
    logic [7:0] Len;
    logic       ErrChk;
    logic       ErrLen;
    logic       ErrTimeout;
    logic       Overrun;
    logic       Busy;

    always #5 Clk = ~Clk;

    uart_frame_parser dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .RxData     (RxData),
        .RxDone     (RxDone),
        .FrameAck   (FrameAck),
        .RdAddr     (RdAddr),
        .RdData     (RdData),
        .FrameValid (FrameValid),
        .Cmd        (Cmd),
        .Len        (Len),
        .ErrChk     (ErrChk),
        .ErrLen     (ErrLen),
        .ErrTimeout (ErrTimeout),
        .Overrun    (Overrun),
        .Busy       (Busy)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: a frame is the list of bytes after SOF; meaning follows from its length.
    bit         m_in_frame, m_held;
    logic [7:0] m_q[$];
    logic [7:0] m_cmd, m_len;
    logic [7:0] m_pay [16];
    int         m_gap;
    bit         m_echk, m_elen, m_eto, m_ovr;

    always @(posedge Clk) begin
        if (Reset) begin
            m_in_frame = 0; m_held = 0; m_q.delete();
            m_cmd = 8'h00; m_len = 8'h00; m_gap = 0;
            m_echk = 0; m_elen = 0; m_eto = 0; m_ovr = 0;
        end else begin
            m_echk = 0; m_elen = 0; m_eto = 0; m_ovr = 0;
            if (m_held) begin
                if (RxDone) m_ovr = 1;
                if (FrameAck) m_held = 0;
            end else if (!m_in_frame) begin
                if (RxDone && RxData == 8'hA5) begin
                    m_in_frame = 1; m_q.delete(); m_gap = 0;
                end
            end else if (RxDone) begin
                int n;
                m_gap = 0;
                m_q.push_back(RxData);
                n = m_q.size();
                if (n == 1) m_cmd = m_q[0];
                else if (n == 2) begin
                    m_len = m_q[1];
                    if (int'(m_len) > MAX_LEN) begin m_elen = 1; m_in_frame = 0; end
                end else if (n <= int'(m_len) + 2) m_pay[n-3] = m_q[n-1];
                if (m_in_frame && n >= 2 && n == int'(m_len) + 3) begin
                    logic [7:0] x;
                    x = 8'h00;
                    for (int i = 0; i < n - 1; i++) x = x ^ m_q[i];
                    if (x == m_q[n-1]) m_held = 1; else m_echk = 1;
                    m_in_frame = 0;
                end
            end else begin
                m_gap++;
                if (m_gap == TIMEOUT_CYC) begin m_eto = 1; m_in_frame = 0; end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("frame_valid", FrameValid, m_held);
            check("busy", Busy, m_in_frame || m_held);
            check("cmd", Cmd, m_cmd);
            check("len", Len, m_len);
            check("err_chk", ErrChk, m_echk);
            check("err_len", ErrLen, m_elen);
            check("err_timeout", ErrTimeout, m_eto);
            check("overrun", Overrun, m_ovr);
            if (m_held) check("rd_data", RdData, m_pay[RdAddr]);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RxData = b;
        RxDone = 1'b1;
        tick();
        RxDone = 1'b0;
        RxData = 8'h00;
    endtask

    task automatic ack();
        FrameAck = 1'b1;
        tick();
        FrameAck = 1'b0;
    endtask

    task automatic read_pay(input logic [3:0] a, input logic [7:0] exp, input string name);
        RdAddr = a;
        #1;
        check(name, RdData, exp);
    endtask

    initial begin
        Reset = 1'b1; RxData = 8'h00; RxDone = 1'b0; FrameAck = 1'b0; RdAddr = 4'd0;
        repeat (3) tick();
        chk_en = 1'b1;
        Reset = 1'b0;
        check("rst_frame_valid", FrameValid, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_cmd", Cmd, 8'h00);
        check("rst_len", Len, 8'h00);

        // Good frame, read back, release
        send(8'hA5); send(8'h01); send(8'h02); send(8'h11); send(8'h22); send(8'h30);
        check("t1_valid", FrameValid, 1'b1);
        check("t1_cmd", Cmd, 8'h01);
        check("t1_len", Len, 8'h02);
        read_pay(4'd0, 8'h11, "t1_rd0");
        read_pay(4'd1, 8'h22, "t1_rd1");
        ack();
        check("t1_released", FrameValid, 1'b0);
        check("t1_idle", Busy, 1'b0);

        // Bad checksum
        send(8'hA5); send(8'h01); send(8'h02); send(8'h11); send(8'h22); send(8'h31);
        check("t2_errchk", ErrChk, 1'b1);
        check("t2_valid", FrameValid, 1'b0);
        tick();
        check("t2_errchk_end", ErrChk, 1'b0);
        check("t2_idle", Busy, 1'b0);

        // Junk before SOF, oversize LEN, then a zero-length frame
        send(8'h3C);
        check("t3_ignored", Busy, 1'b0);
        send(8'hA5); send(8'h05); send(8'h11);
        check("t3_errlen", ErrLen, 1'b1);
        tick();
        send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
        check("t3_valid", FrameValid, 1'b1);
        check("t3_len", Len, 8'h00);
        check("t3_cmd", Cmd, 8'h07);
        ack();

        // Timeout, then a byte just inside the window
        send(8'hA5); send(8'h01);
        repeat (TIMEOUT_CYC) tick();
        check("t4_timeout", ErrTimeout, 1'b1);
        check("t4_idle", Busy, 1'b0);
        tick();
        send(8'hA5); send(8'h01);
        repeat (TIMEOUT_CYC - 1) tick();
        send(8'h00);
        check("t4_no_timeout", ErrTimeout, 1'b0);
        check("t4_busy", Busy, 1'b1);
        send(8'h01);
        check("t4_valid", FrameValid, 1'b1);
        ack();

        // Overrun while held, then ack together with a byte
        send(8'hA5); send(8'h03); send(8'h01); send(8'h5A); send(8'h58);
        check("t5_valid", FrameValid, 1'b1);
        send(8'h55);
        check("t5_overrun", Overrun, 1'b1);
        check("t5_cmd", Cmd, 8'h03);
        check("t5_len", Len, 8'h01);
        read_pay(4'd0, 8'h5A, "t5_rd0");
        RxData = 8'h66; RxDone = 1'b1; FrameAck = 1'b1;
        tick();
        RxDone = 1'b0; FrameAck = 1'b0; RxData = 8'h00;
        check("t5_overrun_ack", Overrun, 1'b1);
        check("t5_released", FrameValid, 1'b0);
        tick();
        check("t5_overrun_end", Overrun, 1'b0);

        // Reset mid-payload, then a clean frame
        send(8'hA5); send(8'h04); send(8'h05); send(8'h01); send(8'h02); send(8'h03);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t6_valid", FrameValid, 1'b0);
        check("t6_busy", Busy, 1'b0);
        check("t6_cmd", Cmd, 8'h00);
        check("t6_len", Len, 8'h00);
        check("t6_errs", {ErrChk, ErrLen, ErrTimeout, Overrun}, 4'b0000);
        send(8'hA5); send(8'h02); send(8'h01); send(8'hEE); send(8'hED);
        check("t6_accept", FrameValid, 1'b1);
        check("t6_cmd2", Cmd, 8'h02);
        check("t6_len2", Len, 8'h01);
        read_pay(4'd0, 8'hEE, "t6_rd0");
        ack();

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
